// File: rtl/operand_pkg.sv
// Shared definitions for the operand-2 shifter and its immediate encoder:
// FSM states, shift-field type codes and field widths.
package operand_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SEARCH     = 2'd1,
        ST_SEARCH_INV = 2'd2,
        ST_DONE       = 2'd3
    } enc_state_t;

    localparam logic [2:0] TYPE_DP_IMM_SHIFT = 3'b000;
    localparam logic [2:0] TYPE_DP_IMM       = 3'b001;
    localparam logic [2:0] TYPE_LS_IMM       = 3'b010;
    localparam logic [2:0] TYPE_LS_REG       = 3'b011;

    localparam int ROT_W = 4;
    localparam int IMM_W = 8;

    // Full 32-bit circular left rotate by an even amount 2*rot (0..30).
    function automatic logic [31:0] rol_even(input logic [31:0] val,
                                             input logic [ROT_W-1:0] rot);
        logic [63:0] dbl;
        dbl = {val, val} << {rot, 1'b0};
        return dbl[63:32];
    endfunction

endpackage

// File: rtl/imm_rot_check.sv
// Tests whether val is imm8 ROR (2*rot) for some imm8, i.e. whether rotating
// val left by 2*rot leaves only the low byte populated.
module imm_rot_check
    import operand_pkg::*;
(
    input  logic [31:0]      val,
    input  logic [ROT_W-1:0] rot,
    output logic             fits,
    output logic [IMM_W-1:0] imm8
);

    logic [31:0] cand;

    always_comb begin
        cand = rol_even(val, rot);
        fits = (cand[31:IMM_W] == '0);
        imm8 = cand[IMM_W-1:0];
    end

endmodule

// File: rtl/imm_operand_encoder.sv
// Sequential search for the ARM data-processing immediate {rot, imm8} of a
// 32-bit constant, optionally retrying on the inverted value.
module imm_operand_encoder
    import operand_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int TRY_INVERT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] value_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [11:0]       shift_out,
    output logic [2:0]        type_out,
    output logic              ok_out,
    output logic              inv_out
);

    enc_state_t        state_q, state_d;
    logic [31:0]       val_q, val_d;
    logic [ROT_W-1:0]  rot_q, rot_d;
    logic [11:0]       shift_q, shift_d;
    logic [2:0]        type_q, type_d;
    logic              ok_q, ok_d;
    logic              inv_q, inv_d;

    logic              fits;
    logic [IMM_W-1:0]  imm8;

    imm_rot_check u_rot_check (
        .val  (val_q),
        .rot  (rot_q),
        .fits (fits),
        .imm8 (imm8)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            val_q   <= '0;
            rot_q   <= '0;
            shift_q <= '0;
            type_q  <= TYPE_DP_IMM_SHIFT;
            ok_q    <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            rot_q   <= rot_d;
            shift_q <= shift_d;
            type_q  <= type_d;
            ok_q    <= ok_d;
            inv_q   <= inv_d;
        end
    end

    // Result registers are zero outside DONE, so outputs only ever show a live result.
    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        rot_d   = rot_q;
        shift_d = shift_q;
        type_d  = type_q;
        ok_d    = ok_q;
        inv_d   = inv_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    val_d   = value_in;
                    rot_d   = '0;
                    state_d = ST_SEARCH;
                end
            end
            ST_SEARCH, ST_SEARCH_INV: begin
                if (fits) begin
                    shift_d = {rot_q, imm8};
                    type_d  = TYPE_DP_IMM;
                    ok_d    = 1'b1;
                    inv_d   = (state_q == ST_SEARCH_INV);
                    state_d = ST_DONE;
                end else if (rot_q == 4'hF) begin
                    if (state_q == ST_SEARCH && TRY_INVERT != 0) begin
                        val_d   = ~val_q;
                        rot_d   = '0;
                        state_d = ST_SEARCH_INV;
                    end else begin
                        shift_d = '0;
                        type_d  = TYPE_DP_IMM_SHIFT;
                        ok_d    = 1'b0;
                        inv_d   = 1'b0;
                        state_d = ST_DONE;
                    end
                end else begin
                    rot_d = rot_q + 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    shift_d = '0;
                    type_d  = TYPE_DP_IMM_SHIFT;
                    ok_d    = 1'b0;
                    inv_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign shift_out = shift_q;
    assign type_out  = type_q;
    assign ok_out    = ok_q;
    assign inv_out   = inv_q;

endmodule

// File: tb/tb_imm_operand_encoder.sv
// Directed bench for imm_operand_encoder: one instance with TRY_INVERT=1 and
// one with TRY_INVERT=0, checking results, latencies, stalls and reset abort.
module tb_imm_operand_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, ok_out, inv_out;
    logic [31:0] value_in;
    logic [11:0] shift_out;
    logic [2:0]  type_out;

    logic        ni_in_valid, ni_in_ready, ni_out_valid, ni_out_ready, ni_ok_out, ni_inv_out;
    logic [31:0] ni_value_in;
    logic [11:0] ni_shift_out;
    logic [2:0]  ni_type_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_operand_encoder #(.DATA_W(32), .TRY_INVERT(1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .value_in(value_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .shift_out(shift_out), .type_out(type_out), .ok_out(ok_out), .inv_out(inv_out)
    );

    imm_operand_encoder #(.DATA_W(32), .TRY_INVERT(0)) dut_ni (
        .clk(clk), .reset(reset),
        .in_valid(ni_in_valid), .in_ready(ni_in_ready), .value_in(ni_value_in),
        .out_valid(ni_out_valid), .out_ready(ni_out_ready),
        .shift_out(ni_shift_out), .type_out(ni_type_out), .ok_out(ni_ok_out), .inv_out(ni_inv_out)
    );

    // Independent decode of the shift field, as the operand-2 shifter would do it.
    function automatic logic [31:0] decode_imm(input logic [11:0] f);
        logic [63:0] dbl;
        logic [31:0] imm;
        imm = {24'd0, f[7:0]};
        dbl = {imm, imm} >> (2 * f[11:8]);
        return dbl[31:0];
    endfunction

    task automatic accept(input logic [31:0] v);
        in_valid = 1'b1;
        value_in = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 64) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, shift_out, type_out, ok_out, inv_out} !== {1'b1, 1'b0, 12'h000, 3'b000, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b sh=%h ty=%b ok=%b inv=%b, want rdy=1 rest 0",
                     in_ready, out_valid, shift_out, type_out, ok_out, inv_out);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat;
        logic [31:0] vals [2] = '{32'h000000FF, 32'h00000000};
        logic [11:0] exps [2] = '{12'h0FF, 12'h000};
        for (int i = 0; i < 2; i++) begin
            accept(vals[i]);
            wait_done(lat);
            checks++;
            if ({shift_out, type_out, ok_out, inv_out} !== {exps[i], 3'b001, 1'b1, 1'b0}) begin
                errors++;
                $display("[TB] FAIL basic_result[%0d]: got sh=%h ty=%b ok=%b inv=%b, want sh=%h ty=001 ok=1 inv=0",
                         i, shift_out, type_out, ok_out, inv_out, exps[i]);
            end
            checks++;
            if (lat !== 1) begin
                errors++;
                $display("[TB] FAIL basic_latency[%0d]: got %0d, want 1", i, lat);
            end
            drain();
        end
    endtask

    task automatic test_rotations();
        int lat;
        logic [31:0] vals [2] = '{32'hFF000000, 32'h000003FC};
        logic [11:0] exps [2] = '{12'h4FF, 12'hFFF};
        int          lats [2] = '{5, 16};
        for (int i = 0; i < 2; i++) begin
            accept(vals[i]);
            wait_done(lat);
            checks++;
            if ({shift_out, type_out, ok_out, inv_out} !== {exps[i], 3'b001, 1'b1, 1'b0}) begin
                errors++;
                $display("[TB] FAIL rot_result[%0d]: got sh=%h ty=%b ok=%b inv=%b, want sh=%h ty=001 ok=1 inv=0",
                         i, shift_out, type_out, ok_out, inv_out, exps[i]);
            end
            checks++;
            if (lat !== lats[i]) begin
                errors++;
                $display("[TB] FAIL rot_latency[%0d]: got %0d, want %0d", i, lat, lats[i]);
            end
            checks++;
            if (decode_imm(shift_out) !== vals[i]) begin
                errors++;
                $display("[TB] FAIL rot_roundtrip[%0d]: decoded %h, want %h", i, decode_imm(shift_out), vals[i]);
            end
            drain();
        end
    endtask

    task automatic test_invert();
        int lat;
        accept(32'hFFFFFF00);
        wait_done(lat);
        checks++;
        if ({shift_out, type_out, ok_out, inv_out} !== {12'h0FF, 3'b001, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL inv_result: got sh=%h ty=%b ok=%b inv=%b, want sh=0ff ty=001 ok=1 inv=1",
                     shift_out, type_out, ok_out, inv_out);
        end
        checks++;
        if (lat !== 17) begin
            errors++;
            $display("[TB] FAIL inv_latency: got %0d, want 17", lat);
        end
        checks++;
        if (~decode_imm(shift_out) !== 32'hFFFFFF00) begin
            errors++;
            $display("[TB] FAIL inv_roundtrip: decoded ~%h, want ffffff00", decode_imm(shift_out));
        end
        drain();
    endtask

    task automatic test_no_invert();
        int lat;
        ni_in_valid = 1'b1;
        ni_value_in = 32'hFFFFFF00;
        @(posedge clk); #1;
        ni_in_valid = 1'b0;
        lat = 0;
        while (lat < 64) begin
            @(posedge clk); #1;
            lat++;
            if (ni_out_valid) break;
        end
        checks++;
        if ({ni_shift_out, ni_type_out, ni_ok_out, ni_inv_out} !== {12'h000, 3'b000, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL noinv_result: got sh=%h ty=%b ok=%b inv=%b, want all 0",
                     ni_shift_out, ni_type_out, ni_ok_out, ni_inv_out);
        end
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("[TB] FAIL noinv_latency: got %0d, want 16", lat);
        end
        ni_out_ready = 1'b1;
        @(posedge clk); #1;
        ni_out_ready = 1'b0;
        checks++;
        if ({ni_out_valid, ni_in_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL noinv_drain: got vld=%b rdy=%b, want vld=0 rdy=1", ni_out_valid, ni_in_ready);
        end
    endtask

    task automatic test_fail_hold();
        int lat;
        int bad_ready = 0;
        int unstable = 0;
        accept(32'h00000101);
        // A competing request during the search must be ignored.
        in_valid = 1'b1;
        value_in = 32'h000000FF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (in_ready !== 1'b0) bad_ready++;
        end
        in_valid = 1'b0;
        wait_done(lat);
        lat += 3;
        checks++;
        if ({shift_out, type_out, ok_out, inv_out} !== {12'h000, 3'b000, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL fail_result: got sh=%h ty=%b ok=%b inv=%b, want all 0",
                     shift_out, type_out, ok_out, inv_out);
        end
        checks++;
        if (lat !== 32) begin
            errors++;
            $display("[TB] FAIL fail_latency: got %0d, want 32", lat);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if ({out_valid, in_ready, shift_out, type_out, ok_out, inv_out} !== {1'b1, 1'b0, 12'h000, 3'b000, 1'b0, 1'b0})
                unstable++;
        end
        checks++;
        if (bad_ready != 0 || unstable != 0) begin
            errors++;
            $display("[TB] FAIL hold_stable: ready_during_search=%0d unstable_hold_cycles=%0d, want 0 and 0",
                     bad_ready, unstable);
        end
        drain();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL hold_drain: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int emitted = 0;
        accept(32'hFF000000);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, out_valid, shift_out, type_out, ok_out, inv_out} !== {1'b1, 1'b0, 12'h000, 3'b000, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL abort_outputs: got rdy=%b vld=%b sh=%h ty=%b ok=%b inv=%b, want rdy=1 rest 0",
                     in_ready, out_valid, shift_out, type_out, ok_out, inv_out);
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) emitted++;
        end
        checks++;
        if (emitted != 0) begin
            errors++;
            $display("[TB] FAIL abort_no_emit: out_valid seen %0d cycles, want 0", emitted);
        end
        accept(32'h000000FF);
        wait_done(lat);
        checks++;
        if ({shift_out, type_out, ok_out, inv_out, lat} !== {12'h0FF, 3'b001, 1'b1, 1'b0, 32'd1}) begin
            errors++;
            $display("[TB] FAIL abort_recover: got sh=%h ty=%b ok=%b inv=%b lat=%0d, want sh=0ff ty=001 ok=1 inv=0 lat=1",
                     shift_out, type_out, ok_out, inv_out, lat);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int lat;
        accept(32'h00000000);
        wait_done(lat);
        drain();
        accept(32'hFF000000);
        wait_done(lat);
        checks++;
        if ({shift_out, ok_out, lat} !== {12'h4FF, 1'b1, 32'd5}) begin
            errors++;
            $display("[TB] FAIL back_to_back: got sh=%h ok=%b lat=%0d, want sh=4ff ok=1 lat=5",
                     shift_out, ok_out, lat);
        end
        drain();
    endtask

    initial begin
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        value_in     = '0;
        ni_in_valid  = 1'b0;
        ni_out_ready = 1'b0;
        ni_value_in  = '0;
        test_reset();
        test_basic();
        test_rotations();
        test_invert();
        test_no_invert();
        test_fail_hold();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
